// File: rtl/arashi_pkg.sv
// Shared encodings for the arashi cache request issuer: cache ctrl lane codes,
// request opcode and issue-FSM state types.
package arashi_pkg;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_RD   = 2'b01;
    localparam logic [1:0] CTRL_WR   = 2'b10;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arashi_op_e;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'b00,
        ISS_RUN   = 2'b01,
        ISS_DRAIN = 2'b10
    } arashi_iss_state_e;

    function automatic logic [1:0] ctrl_for_op(arashi_op_e op);
        return (op == OP_WR) ? CTRL_WR : CTRL_RD;
    endfunction

endpackage

// File: rtl/arashi_req_fifo.sv
// Per-thread request FIFO for the arashi issuer; count-based full/empty,
// power-of-two depth so the pointers wrap naturally.
module arashi_req_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Full is judged on current occupancy, so a pop never makes room for a same-edge push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arashi_req_issuer.sv
// Issue stage for the arashi cache: per-thread request FIFOs, run/drain issue FSM,
// registered cache ctrl lanes and fixed-latency read return. ARASHI_ISSUER_STATS_EN adds issue counters.
module arashi_req_issuer
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int THREAD_NUM = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [THREAD_NUM-1:0]            req_valid,
    output logic [THREAD_NUM-1:0]            req_ready,
    input  logic [THREAD_NUM-1:0]            req_op,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0] req_data,
    output logic [THREAD_NUM*2-1:0]          cache_ctrl,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] cache_wdata,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0] cache_rdata,
    output logic [THREAD_NUM-1:0]            rsp_valid,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] rsp_data,
    output logic                             busy
`ifdef ARASHI_ISSUER_STATS_EN
    ,
    output logic [32*THREAD_NUM-1:0]         stat_wr_cnt,
    output logic [32*THREAD_NUM-1:0]         stat_rd_cnt
`endif
);

    if ((THREAD_NUM % 4) != 0 || THREAD_NUM >= 32) begin : g_bad_thread_num
        $error("arashi_req_issuer: THREAD_NUM must be a multiple of 4 and below 32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("arashi_req_issuer: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("arashi_req_issuer: RD_LAT must be at least 1");
    end

    arashi_iss_state_e state;
    arashi_iss_state_e state_next;

    logic [THREAD_NUM-1:0] full;
    logic [THREAD_NUM-1:0] empty;
    logic [THREAD_NUM-1:0] push;
    logic [THREAD_NUM-1:0] pop;
    logic [DATA_WIDTH:0]   head    [THREAD_NUM];
    logic [RD_LAT-1:0]     rd_pipe [THREAD_NUM];
    logic                  issue_active;
    logic                  all_empty;
    logic                  reads_in_flight;

    assign issue_active = (state == ISS_RUN) || (state == ISS_DRAIN);
    assign all_empty    = &empty;
    assign busy         = (state != ISS_IDLE) || !all_empty;

    for (genvar i = 0; i < THREAD_NUM; i++) begin : g_lane
        assign req_ready[i] = !full[i] && !rst;
        assign push[i]      = req_valid[i] && req_ready[i];
        assign pop[i]       = issue_active && !empty[i];

        arashi_req_fifo #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data ({req_op[i], req_data[i*DATA_WIDTH +: DATA_WIDTH]}),
            .pop       (pop[i]),
            .pop_data  (head[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // A read counts as in flight from its ctrl strobe until its data has been sampled.
    always_comb begin
        reads_in_flight = 1'b0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            if (cache_ctrl[2*i] || (rd_pipe[i] != '0)) begin
                reads_in_flight = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ISS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ISS_IDLE: begin
                if (en) state_next = ISS_RUN;
            end
            ISS_RUN: begin
                if (!en) state_next = ISS_DRAIN;
            end
            ISS_DRAIN: begin
                if (en) begin
                    state_next = ISS_RUN;
                end else if (all_empty && !reads_in_flight) begin
                    state_next = ISS_IDLE;
                end
            end
            default: state_next = ISS_IDLE;
        endcase
    end

    // Issue registers plus the per-lane read-latency shift register and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_ctrl  <= '0;
            cache_wdata <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            for (int i = 0; i < THREAD_NUM; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i < THREAD_NUM; i++) begin
                if (pop[i]) begin
                    cache_ctrl[2*i +: 2] <= ctrl_for_op(arashi_op_e'(head[i][DATA_WIDTH]));
                    cache_wdata[i*DATA_WIDTH +: DATA_WIDTH] <=
                        (arashi_op_e'(head[i][DATA_WIDTH]) == OP_WR) ? head[i][DATA_WIDTH-1:0] : '0;
                end else begin
                    cache_ctrl[2*i +: 2] <= CTRL_IDLE;
                    cache_wdata[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
                rd_pipe[i]   <= RD_LAT'({rd_pipe[i], cache_ctrl[2*i]});
                rsp_valid[i] <= rd_pipe[i][RD_LAT-1];
                if (rd_pipe[i][RD_LAT-1]) begin
                    rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= cache_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef ARASHI_ISSUER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            for (int i = 0; i < THREAD_NUM; i++) begin
                if (pop[i] && (arashi_op_e'(head[i][DATA_WIDTH]) == OP_WR)) begin
                    if (stat_wr_cnt[32*i +: 32] != '1) begin
                        stat_wr_cnt[32*i +: 32] <= stat_wr_cnt[32*i +: 32] + 32'd1;
                    end
                end
                if (pop[i] && (arashi_op_e'(head[i][DATA_WIDTH]) == OP_RD)) begin
                    if (stat_rd_cnt[32*i +: 32] != '1) begin
                        stat_rd_cnt[32*i +: 32] <= stat_rd_cnt[32*i +: 32] + 32'd1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_arashi_req_issuer.sv
// Self-checking bench for arashi_req_issuer: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the issuer.
module tb_arashi_req_issuer;

    localparam int DW     = 32;
    localparam int NT     = 4;
    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;

    localparam int M_STOPPED  = 0;
    localparam int M_ACTIVE   = 1;
    localparam int M_DRAINING = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NT-1:0]    req_valid;
    logic [NT-1:0]    req_ready;
    logic [NT-1:0]    req_op;
    logic [DW*NT-1:0] req_data;
    logic [2*NT-1:0]  cache_ctrl;
    logic [DW*NT-1:0] cache_wdata;
    logic [DW*NT-1:0] cache_rdata;
    logic [NT-1:0]    rsp_valid;
    logic [DW*NT-1:0] rsp_data;
    logic             busy;
`ifdef ARASHI_ISSUER_STATS_EN
    logic [32*NT-1:0] stat_wr_cnt;
    logic [32*NT-1:0] stat_rd_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued requests, issue cycles of outstanding reads, issue mode.
    logic [DW:0]      mq  [NT][$];
    int               rdq [NT][$];
    int               mode;
    int               cyc;
    logic [2*NT-1:0]  exp_ctrl;
    logic [DW*NT-1:0] exp_wdata;
    logic [NT-1:0]    exp_rsp_valid;
    logic [DW*NT-1:0] exp_rsp_data;

    arashi_req_issuer #(
        .DATA_WIDTH (DW),
        .THREAD_NUM (NT),
        .FIFO_DEPTH (DEPTH),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .cache_ctrl  (cache_ctrl),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
`ifdef ARASHI_ISSUER_STATS_EN
        ,
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Predicts the effect of the coming clock edge from the inputs currently driven.
    task automatic model_edge();
        logic [NT-1:0] can_push;
        logic          any_queued;
        logic          any_reads;
        logic [DW:0]   e;
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                mq[i].delete();
                rdq[i].delete();
            end
            mode          = M_STOPPED;
            exp_ctrl      = '0;
            exp_wdata     = '0;
            exp_rsp_valid = '0;
            exp_rsp_data  = '0;
            return;
        end
        any_queued = 1'b0;
        any_reads  = 1'b0;
        for (int i = 0; i < NT; i++) begin
            can_push[i] = (mq[i].size() < DEPTH);
            if (mq[i].size() != 0) any_queued = 1'b1;
            if (rdq[i].size() != 0) any_reads = 1'b1;
        end
        for (int i = 0; i < NT; i++) begin
            exp_rsp_valid[i] = 1'b0;
            if (rdq[i].size() != 0 && rdq[i][0] + RD_LAT == cyc) begin
                exp_rsp_valid[i] = 1'b1;
                exp_rsp_data[i*DW +: DW] = cache_rdata[i*DW +: DW];
                void'(rdq[i].pop_front());
            end
            exp_ctrl[2*i +: 2]    = 2'b00;
            exp_wdata[i*DW +: DW] = '0;
            if (mode != M_STOPPED && mq[i].size() != 0) begin
                e = mq[i].pop_front();
                if (e[DW]) begin
                    exp_ctrl[2*i +: 2]    = 2'b10;
                    exp_wdata[i*DW +: DW] = e[DW-1:0];
                end else begin
                    exp_ctrl[2*i +: 2] = 2'b01;
                    rdq[i].push_back(cyc + 1);
                end
            end
            if (req_valid[i] && can_push[i]) begin
                mq[i].push_back({req_op[i], req_data[i*DW +: DW]});
            end
        end
        case (mode)
            M_STOPPED:  if (en) mode = M_ACTIVE;
            M_ACTIVE:   if (!en) mode = M_DRAINING;
            default: begin
                if (en) mode = M_ACTIVE;
                else if (!any_queued && !any_reads) mode = M_STOPPED;
            end
        endcase
    endtask

    task automatic step_cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NT; i++) cache_rdata[i*DW +: DW] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; req_valid = '1; req_op = '0;
        for (int i = 0; i < NT; i++) req_data[i*DW +: DW] = $urandom;
        for (int k = 0; k < 3; k++) begin
            step_cycle();
            n_cmp++;
            if (req_ready !== '0) begin n_bad++; $display("[TB] FAIL reset_ready: got %h required 0", req_ready); end
        end
        rst = 1'b0; req_valid = '0;
        #1;
        n_cmp++; if (req_ready !== 4'hF) begin n_bad++; $display("[TB] FAIL post_reset_ready: got %h required f", req_ready); end
        n_cmp++; if (cache_ctrl !== '0) begin n_bad++; $display("[TB] FAIL post_reset_ctrl: got %h required 0", cache_ctrl); end
        n_cmp++; if (cache_wdata !== '0) begin n_bad++; $display("[TB] FAIL post_reset_wdata: got %h required 0", cache_wdata); end
        n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("[TB] FAIL post_reset_rsp_valid: got %h required 0", rsp_valid); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("[TB] FAIL post_reset_rsp_data: got %h required 0", rsp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_write();
        en = 1'b1;
        step_cycle();
        req_valid = 4'b0001; req_op = 4'b0001; req_data[31:0] = 32'hDEADBEEF;
        step_cycle();
        req_valid = '0;
        n_cmp++; if (cache_ctrl[1:0] !== 2'b00) begin n_bad++; $display("[TB] FAIL write_early: got %b required 00", cache_ctrl[1:0]); end
        step_cycle();
        n_cmp++; if (cache_ctrl[1:0] !== 2'b10) begin n_bad++; $display("[TB] FAIL write_ctrl: got %b required 10", cache_ctrl[1:0]); end
        n_cmp++; if (cache_wdata[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL write_wdata: got %h required deadbeef", cache_wdata[31:0]); end
        step_cycle();
        n_cmp++; if (cache_ctrl[1:0] !== 2'b00) begin n_bad++; $display("[TB] FAIL write_one_cycle: got %b required 00", cache_ctrl[1:0]); end
        n_cmp++; if (cache_wdata[31:0] !== 32'h0) begin n_bad++; $display("[TB] FAIL write_wdata_clear: got %h required 0", cache_wdata[31:0]); end
    endtask

    task automatic test_read();
        req_valid = 4'b0100; req_op = 4'b0000;
        step_cycle();
        req_valid = '0;
        step_cycle();
        n_cmp++; if (cache_ctrl[5:4] !== 2'b01) begin n_bad++; $display("[TB] FAIL read_ctrl: got %b required 01", cache_ctrl[5:4]); end
        n_cmp++; if (cache_wdata[95:64] !== 32'h0) begin n_bad++; $display("[TB] FAIL read_wdata: got %h required 0", cache_wdata[95:64]); end
        for (int k = 0; k < 2; k++) begin
            step_cycle();
            n_cmp++; if (rsp_valid[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL read_early_rsp: got %b required 0", rsp_valid[2]); end
        end
        cache_rdata[95:64] = 32'h12345678;
        step_cycle();
        n_cmp++; if (rsp_valid[2] !== 1'b1) begin n_bad++; $display("[TB] FAIL read_rsp_valid: got %b required 1", rsp_valid[2]); end
        n_cmp++; if (rsp_data[95:64] !== 32'h12345678) begin n_bad++; $display("[TB] FAIL read_rsp_data: got %h required 12345678", rsp_data[95:64]); end
        step_cycle();
        n_cmp++; if (rsp_valid[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL read_rsp_pulse: got %b required 0", rsp_valid[2]); end
        n_cmp++; if (rsp_data[95:64] !== 32'h12345678) begin n_bad++; $display("[TB] FAIL read_rsp_hold: got %h required 12345678", rsp_data[95:64]); end
    endtask

    task automatic test_full();
        logic [DW-1:0] d [5];
        en = 1'b0;
        for (int k = 0; k < 10 && mode != M_STOPPED; k++) step_cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL full_idle_busy: got %b required 0", busy); end
        for (int j = 0; j < 5; j++) begin
            d[j] = $urandom;
            req_valid = 4'b0010; req_op = 4'b0010; req_data[63:32] = d[j];
            #1;
            if (j == 4) begin
                n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("[TB] FAIL full_ready: got %b required 0", req_ready[1]); end
            end
            step_cycle();
        end
        req_valid = '0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL full_busy: got %b required 1", busy); end
        n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("[TB] FAIL full_ready_hold: got %b required 0", req_ready[1]); end
        en = 1'b1;
        step_cycle();
        n_cmp++; if (cache_ctrl[3:2] !== 2'b00) begin n_bad++; $display("[TB] FAIL full_no_issue_idle: got %b required 00", cache_ctrl[3:2]); end
        for (int j = 0; j < 4; j++) begin
            step_cycle();
            n_cmp++; if (cache_ctrl[3:2] !== 2'b10) begin n_bad++; $display("[TB] FAIL full_issue_ctrl[%0d]: got %b required 10", j, cache_ctrl[3:2]); end
            n_cmp++; if (cache_wdata[63:32] !== d[j]) begin n_bad++; $display("[TB] FAIL full_issue_data[%0d]: got %h required %h", j, cache_wdata[63:32], d[j]); end
        end
        step_cycle();
        n_cmp++; if (cache_ctrl[3:2] !== 2'b00) begin n_bad++; $display("[TB] FAIL full_fifth_dropped: got %b required 00", cache_ctrl[3:2]); end
        n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL full_ready_back: got %b required 1", req_ready[1]); end
    endtask

    task automatic test_drain();
        int seen = 0;
        en = 1'b1; req_valid = 4'b1000; req_op = 4'b0000;
        step_cycle();
        step_cycle();
        req_valid = '0; en = 1'b0;
        n_cmp++; if (cache_ctrl[7:6] !== 2'b01) begin n_bad++; $display("[TB] FAIL drain_first_read: got %b required 01", cache_ctrl[7:6]); end
        step_cycle();
        n_cmp++; if (cache_ctrl[7:6] !== 2'b01) begin n_bad++; $display("[TB] FAIL drain_second_read: got %b required 01", cache_ctrl[7:6]); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++; if (rsp_valid[3] !== exp_rsp_valid[3]) begin n_bad++; $display("[TB] FAIL drain_rsp_valid: got %b required %b", rsp_valid[3], exp_rsp_valid[3]); end
            n_cmp++; if (rsp_data[127:96] !== exp_rsp_data[127:96]) begin n_bad++; $display("[TB] FAIL drain_rsp_data: got %h required %h", rsp_data[127:96], exp_rsp_data[127:96]); end
            if (rsp_valid[3] === 1'b1) seen++;
            step_cycle();
        end
        n_cmp++; if (seen != 2) begin n_bad++; $display("[TB] FAIL drain_rsp_count: got %0d required 2", seen); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL drain_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; req_valid = '1; req_op = '0;
        step_cycle();
        req_valid = '0;
        step_cycle();
        n_cmp++; if (cache_ctrl !== 8'h55) begin n_bad++; $display("[TB] FAIL rstmid_reads: got %h required 55", cache_ctrl); end
        step_cycle();
        rst = 1'b1; en = 1'b0;
        step_cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("[TB] FAIL rstmid_rsp_valid: got %h required 0", rsp_valid); end
            n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("[TB] FAIL rstmid_rsp_data: got %h required 0", rsp_data); end
            n_cmp++; if (cache_ctrl !== '0) begin n_bad++; $display("[TB] FAIL rstmid_ctrl: got %h required 0", cache_ctrl); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid_busy: got %b required 0", busy); end
            step_cycle();
        end
    endtask

    task automatic test_random();
        logic [NT-1:0] exp_ready;
        logic          exp_busy;
        for (int k = 0; k < 600; k++) begin
            exp_busy = (mode != M_STOPPED);
            for (int i = 0; i < NT; i++) begin
                exp_ready[i] = !rst && (mq[i].size() < DEPTH);
                if (mq[i].size() != 0) exp_busy = 1'b1;
            end
            n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("[TB] FAIL rand_ready @%0d: got %h required %h", cyc, req_ready, exp_ready); end
            n_cmp++; if (cache_ctrl !== exp_ctrl) begin n_bad++; $display("[TB] FAIL rand_ctrl @%0d: got %h required %h", cyc, cache_ctrl, exp_ctrl); end
            n_cmp++; if (cache_wdata !== exp_wdata) begin n_bad++; $display("[TB] FAIL rand_wdata @%0d: got %h required %h", cyc, cache_wdata, exp_wdata); end
            n_cmp++; if (rsp_valid !== exp_rsp_valid) begin n_bad++; $display("[TB] FAIL rand_rsp_valid @%0d: got %h required %h", cyc, rsp_valid, exp_rsp_valid); end
            n_cmp++; if (rsp_data !== exp_rsp_data) begin n_bad++; $display("[TB] FAIL rand_rsp_data @%0d: got %h required %h", cyc, rsp_data, exp_rsp_data); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("[TB] FAIL rand_busy @%0d: got %b required %b", cyc, busy, exp_busy); end
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) en = ~en;
            req_valid = NT'($urandom);
            req_op    = NT'($urandom);
            for (int i = 0; i < NT; i++) req_data[i*DW +: DW] = $urandom;
            step_cycle();
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        cyc = 0;
        mode = M_STOPPED;
        for (int i = 0; i < NT; i++) cache_rdata[i*DW +: DW] = $urandom;
        test_reset();
        test_write();
        test_read();
        test_full();
        test_drain();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
